// File: rtl/cache_fill_arbiter.sv
// Arbitrates the shared memory port between I-cache/D-cache block fills and
// D-side write-through stores; steers returning fill words into the granted cache.
module cache_fill_arbiter #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_miss,
  input  logic [15:0]                        i_miss_addr,
  input  logic                               d_miss,
  input  logic [15:0]                        d_miss_addr,
  input  logic                               d_wr_req,
  input  logic [15:0]                        d_wr_addr,
  input  logic [15:0]                        d_wr_data,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [15:0]                        mem_addr,
  output logic [15:0]                        mem_wdata,
  input  logic [15:0]                        mem_rdata,
  input  logic                               mem_valid,
  output logic [15:0]                        fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               fill_we_i,
  output logic                               fill_we_d,
  output logic                               tag_we_i,
  output logic                               tag_we_d,
  output logic                               i_fill_done,
  output logic                               d_fill_done,
  output logic                               wr_done,
  output logic                               busy
);

  localparam int WW            = $clog2(WORDS_PER_BLOCK);
  localparam int LAST_I        = WORDS_PER_BLOCK - 1;
  localparam int BLOCK_BYTES_M1 = 2 * WORDS_PER_BLOCK - 1;
  localparam logic [WW-1:0] LAST       = LAST_I[WW-1:0];
  localparam logic [WW:0]   ISSUE_END  = WORDS_PER_BLOCK[WW:0];
  localparam logic [15:0]   ALIGN_MASK = ~BLOCK_BYTES_M1[15:0];

  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 ||
      (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : gParamCheck
    $error("cache_fill_arbiter: bad MEM_LATENCY or WORDS_PER_BLOCK");
  end

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t        state;
  logic          sideD;
  logic [15:0]   base;
  logic [WW:0]   issueCnt;
  logic [WW-1:0] rxCnt;
  logic [15:0]   grantBase;
  logic          rxAccept;
  logic          rxLast;

  assign grantBase = (d_miss ? d_miss_addr : i_miss_addr) & ALIGN_MASK;

  // Only accept a return while a read is actually outstanding in FILL.
  assign rxAccept = (state == FILL) && mem_valid && ({1'b0, rxCnt} < issueCnt);
  assign rxLast   = rxAccept && (rxCnt == LAST);

  assign fill_data = rxAccept ? mem_rdata : '0;
  assign fill_word = rxAccept ? rxCnt : '0;
  assign fill_we_i = rxAccept && !sideD;
  assign fill_we_d = rxAccept && sideD;
  assign tag_we_i  = rxLast && !sideD;
  assign tag_we_d  = rxLast && sideD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sideD       <= 1'b0;
      base        <= '0;
      issueCnt    <= '0;
      rxCnt       <= '0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wr_done     <= 1'b0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_done     <= 1'b0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      case (state)
        IDLE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          if (d_wr_req) begin
            state     <= WRITE;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
            wr_done   <= 1'b1;
          end else if (d_miss || i_miss) begin
            state    <= FILL;
            busy     <= 1'b1;
            sideD    <= d_miss;
            base     <= grantBase;
            mem_en   <= 1'b1;
            mem_addr <= grantBase;
            issueCnt <= {{WW{1'b0}}, 1'b1};
            rxCnt    <= '0;
          end
        end
        WRITE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
        end
        FILL: begin
          if (issueCnt < ISSUE_END) begin
            mem_en   <= 1'b1;
            mem_addr <= base + 16'({issueCnt[WW-1:0], 1'b0});
            issueCnt <= issueCnt + 1'b1;
          end else begin
            mem_en <= 1'b0;
          end
          if (rxAccept) begin
            rxCnt <= rxCnt + 1'b1;
            if (rxCnt == LAST) begin
              state       <= DONE;
              i_fill_done <= !sideD;
              d_fill_done <= sideD;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_en   <= 1'b0;
          issueCnt <= '0;
          rxCnt    <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency pipelined memory model.
module tb_cache_fill_arbiter;

  localparam int L = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d;
  logic        i_fill_done, d_fill_done, wr_done, busy;

  logic          spur;
  logic [15:0]   spurData;
  logic [L-1:0]  vPipe;
  logic [15:0]   dPipe [L];

  int checks = 0;
  int failures = 0;

  cache_fill_arbiter #(.MEM_LATENCY(L), .WORDS_PER_BLOCK(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .tag_we_i(tag_we_i), .tag_we_d(tag_we_d),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .wr_done(wr_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: read data = addr ^ 0x5A5A, returned L cycles after the issue cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      vPipe <= '0;
    end else begin
      vPipe[0] <= mem_en && !mem_wr;
      dPipe[0] <= mem_addr ^ 16'h5A5A;
      for (int i = 1; i < L; i++) begin
        vPipe[i] <= vPipe[i-1];
        dPipe[i] <= dPipe[i-1];
      end
    end
  end

  assign mem_valid = vPipe[L-1] | spur;
  assign mem_rdata = vPipe[L-1] ? dPipe[L-1] : (spur ? spurData : 16'h0000);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ":mem_en"}, mem_en, 0);
    chk({tag, ":mem_wr"}, mem_wr, 0);
    chk({tag, ":mem_addr"}, mem_addr, 0);
    chk({tag, ":mem_wdata"}, mem_wdata, 0);
    chk({tag, ":fill_data"}, fill_data, 0);
    chk({tag, ":fill_word"}, fill_word, 0);
    chk({tag, ":fill_we"}, {fill_we_i, fill_we_d}, 0);
    chk({tag, ":tag_we"}, {tag_we_i, tag_we_d}, 0);
    chk({tag, ":done"}, {i_fill_done, d_fill_done, wr_done}, 0);
    chk({tag, ":busy"}, busy, 0);
  endtask

  // Called in cycle 0 (request already visible); returns in the DONE cycle
  // after dropping the completed request.
  task automatic checkFill(input string tag, input bit sideD, input logic [15:0] base);
    bit weExp;
    for (int k = 1; k <= W + L + 1; k++) begin
      tick();
      chk({tag, ":mem_en"}, mem_en, (k <= W));
      if (k <= W) begin
        chk({tag, ":mem_wr"}, mem_wr, 0);
        chk({tag, ":mem_addr"}, mem_addr, base + 16'(2 * (k - 1)));
      end
      weExp = (k >= 1 + L) && (k <= W + L);
      chk({tag, ":fill_we_own"}, sideD ? fill_we_d : fill_we_i, weExp);
      chk({tag, ":fill_we_other"}, sideD ? fill_we_i : fill_we_d, 0);
      if (weExp) begin
        chk({tag, ":fill_word"}, fill_word, k - 1 - L);
        chk({tag, ":fill_data"}, fill_data, (base + 16'(2 * (k - 1 - L))) ^ 16'h5A5A);
      end
      chk({tag, ":tag_we_own"}, sideD ? tag_we_d : tag_we_i, (k == W + L));
      chk({tag, ":tag_we_other"}, sideD ? tag_we_i : tag_we_d, 0);
      chk({tag, ":done_own"}, sideD ? d_fill_done : i_fill_done, (k == W + L + 1));
      chk({tag, ":done_other"}, {(sideD ? i_fill_done : d_fill_done), wr_done}, 0);
      chk({tag, ":busy"}, busy, 1);
    end
    if (sideD) d_miss = 1'b0;
    else i_miss = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i_miss = 0; d_miss = 0; d_wr_req = 0; spur = 0; spurData = 16'h0;
    i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
    tick(); tick();
    chkAllZero("reset");
    rst_n = 1'b1;
    tick();
    chkAllZero("idle_after_reset");

    // I-miss alone at 0x1236 -> block 0x1230
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    checkFill("imiss", 1'b0, 16'h1230);
    tick();
    chk("imiss:idle_after", busy, 0);

    // D and I miss together: D first, I granted in the idle cycle after DONE
    d_miss = 1'b1; d_miss_addr = 16'h4455; i_miss = 1'b1; i_miss_addr = 16'h1236;
    checkFill("dfirst", 1'b1, 16'h4450);
    tick();
    chk("dfirst:gap_busy", busy, 0);
    chk("dfirst:gap_mem_en", mem_en, 0);
    checkFill("ithen", 1'b0, 16'h1230);
    tick();

    // Store
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    tick();
    chk("store:mem_en", mem_en, 1);
    chk("store:mem_wr", mem_wr, 1);
    chk("store:mem_addr", mem_addr, 16'h0040);
    chk("store:mem_wdata", mem_wdata, 16'hBEEF);
    chk("store:wr_done", wr_done, 1);
    chk("store:fill_we", {fill_we_i, fill_we_d}, 0);
    chk("store:busy", busy, 1);
    d_wr_req = 1'b0;
    tick();
    chk("store:idle_busy", busy, 0);
    chk("store:idle_mem_en", mem_en, 0);
    chk("store:wr_done_pulse", wr_done, 0);

    // Store with pending I-miss: store wins, I fill granted at cycle 2
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'h1357;
    i_miss = 1'b1; i_miss_addr = 16'h0A1F;
    tick();
    chk("storei:wr_done", wr_done, 1);
    chk("storei:mem_wr", mem_wr, 1);
    chk("storei:mem_addr", mem_addr, 16'h0100);
    chk("storei:mem_wdata", mem_wdata, 16'h1357);
    d_wr_req = 1'b0;
    tick();
    chk("storei:gap_busy", busy, 0);
    checkFill("storei_fill", 1'b0, 16'h0A10);
    tick();

    // Reset at cycle 7 of a fill
    i_miss = 1'b1; i_miss_addr = 16'h3000;
    for (int k = 1; k <= 7; k++) tick();
    chk("rstmid:busy_before", busy, 1);
    rst_n = 1'b0; i_miss = 1'b0;
    tick();
    chkAllZero("rstmid");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rstmid:no_done", {i_fill_done, d_fill_done, fill_we_i, tag_we_i}, 0);
      chk("rstmid:idle", busy, 0);
    end
    i_miss = 1'b1; i_miss_addr = 16'h2004;
    checkFill("after_rst", 1'b0, 16'h2000);
    tick();

    // Spurious mem_valid in IDLE
    spur = 1'b1; spurData = 16'h1234;
    #1;
    chk("spur_idle:fill_we", {fill_we_i, fill_we_d}, 0);
    chk("spur_idle:tag_we", {tag_we_i, tag_we_d}, 0);
    chk("spur_idle:fill_data", fill_data, 0);
    tick();
    chk("spur_idle:busy", busy, 0);
    // Spurious mem_valid during WRITE
    d_wr_req = 1'b1; d_wr_addr = 16'h0200; d_wr_data = 16'h0F0F;
    tick();
    chk("spur_wr:wr_done", wr_done, 1);
    chk("spur_wr:fill_we", {fill_we_i, fill_we_d}, 0);
    chk("spur_wr:tag_we", {tag_we_i, tag_we_d}, 0);
    d_wr_req = 1'b0; spur = 1'b0;
    tick();
    chk("spur_wr:idle", busy, 0);
    d_miss = 1'b1; d_miss_addr = 16'h7FFE;
    checkFill("after_spur", 1'b1, 16'h7FF0);
    tick();
    chk("final:idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
